zeroriscy_bnn_xnor_acc: RTL and testbench
=========================================

# zeroriscy_bnn_xnor_acc

Multi-cycle BNN execution unit that answers the EX stage's unit handshake (`en` held until `ready`, result sampled in the `ready` cycle), the same handshake the EX stage uses for its mult/div and BNN units. It holds a small binary weight buffer and a signed 32-bit accumulator. It implements XNOR-popcount accumulation and a sign/threshold activation, so a BNN dot product runs as a sequence of custom instructions. The result feeds the EX write-back mux.

## Interface
- `NUM_WORDS`, 16: weight buffer depth in 32-bit words (power of two); index = `bnn_addr_i[$clog2(NUM_WORDS)-1:0]`.
- `clk` in 1: clock. Only clock in the block; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `bnn_en_i` in 1: request valid; held high by EX until `bnn_ready_o`.
- `bnn_operator_i` in 3: operation code; stable while `bnn_en_i` high.
- `bnn_addr_i` in 32: weight word index (upper bits ignored).
- `bnn_data_i` in 32: operand data.
- `bnn_result_o` out 32: result; valid only when `bnn_ready_o`=1, else 0.
- `bnn_ready_o` out 1: handshake complete this cycle; combinational, 0 whenever `bnn_en_i`=0.

## Operation
- Handshake completes on a cycle with `bnn_en_i & bnn_ready_o`. Architectural state (weights, `acc`, `thr`) commits only at that edge.
- Operators, all single-cycle (ready in the first cycle) except XNOR_ACC:
  - 000 LOAD_W: `W[idx] <= data`. Result 0.
  - 001 CLR_ACC: `acc <= 0`. Result 0.
  - 010 XNOR_ACC: multi-cycle. `acc <= acc + 2*popcount(~(data ^ W[idx])) - 32`. Result is the new `acc`.
  - 011 READ_ACC: result `acc`.
  - 100 SIGN: result `{31'b0, $signed(acc) >= $signed(thr)}`.
  - 101 SET_TH: `thr <= data`. Result 0.
  - 110 LOAD_ACC: `acc <= data`. Result 0.
  - 111 reserved: ready immediately, result 0, no state change.
- FSM states IDLE, BUSY, DONE:
  - IDLE, with `en` and XNOR_ACC: latch `x = ~(data ^ W[idx])`, clear `part` (6 bits) and `cnt` (2 bits), go to BUSY. `ready`=0.
  - BUSY: `part += popcount8(x[8*cnt +: 8])`, `cnt++`. When `cnt`==3, go to DONE.
  - DONE: `ready`=1, result `= acc + {part,1'b0} - 32` (32-bit two's complement, wraps mod 2^32). Commit `acc`, go to IDLE.
- Abort: `bnn_en_i` low while in BUSY or DONE returns the FSM to IDLE next edge. `acc` is unchanged and `part` is discarded.
- Back-to-back: `en` still high in the cycle after DONE is a new request, decoded from IDLE. The new request sees the committed `acc`.
- Reset: FSM goes to IDLE; `acc`, `thr`, `part`, `cnt`, and all `W` go to 0. Reset overrides any handshake in the same cycle.

## Timing
- Single-cycle ops: `ready` in the same cycle `en` first rises; latency 0.
- XNOR_ACC: `en` rises at cycle 0; BUSY for cycles 1–4; `ready` at cycle 5. Throughput is one XNOR_ACC per 6 cycles.
- Output values after reset with `en`=0: `bnn_ready_o`=0, `bnn_result_o`=0.
- Result path in DONE is an adder on registered values only; `x` is registered, so there is no combinational path from `bnn_data_i` to result for XNOR_ACC.
- LOAD_W followed immediately by XNOR_ACC on the same index uses the new word, because the weight was written at the previous edge.

## Structure
- Shared package `zeroriscy_defines`: `BNN_OP_*` 3-bit constants, alongside the existing ALU op constants. `bnn_operator_i` width is taken from that package.
- Sub-module `zeroriscy_popcnt8`: combinational 8-bit population count, 4-bit output. One instance, reused each BUSY cycle.
- Weight buffer as a flop array, `NUM_WORDS` x 32.

## Test plan
- Popcount maximum: reset; LOAD_W idx 3 `0xFFFF0000`; XNOR_ACC idx 3 data `0xFFFF0000` -> `ready` exactly at cycle 5, result `0x00000020`; READ_ACC -> `0x20`.
- Popcount minimum and address aliasing: LOAD_W addr `0x13` data `0xFFFF0000` (writes idx 3); CLR; XNOR_ACC idx 3 data `0x0000FFFF` -> result `0xFFFFFFE0` (−32).
- Wrap and back-to-back: LOAD_ACC `0x7FFFFFF0`; XNOR with all bits matching -> `0x80000010`. READ_ACC issued the very next cycle -> `0x80000010`.
- Signed threshold: SET_TH `0x10` with acc 32 -> SIGN 1. With acc 0 -> 0. SET_TH 0, acc `0xFFFFFFE0` -> 0.
- Abort and reset mid-operation: drop `en` at cycle 2 of XNOR -> acc unchanged and the next op is handled normally. Assert `rst` at cycle 3 -> `ready` 0, later READ_ACC returns 0 and a W read back via XNOR reflects zeroed weights.
- Reserved op 111 -> `ready` in the same cycle, result 0, no state change.

Source files
------------

// File: rtl/zeroriscy_defines.sv
// Shared opcode constants for the zeroriscy EX stage: ALU operators plus the
// BNN unit operators and FSM state type.
package zeroriscy_defines;

  localparam int unsigned ALU_OP_WIDTH = 6;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 6'b011000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 6'b011001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 6'b101111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 6'b101110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 6'b010101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 6'b100100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 6'b100101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 6'b100111;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 6'b000000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 6'b000001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 6'b001100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 6'b001101;

  localparam int unsigned BNN_OP_WIDTH = 3;

  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_LOAD_W   = 3'b000;
  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_CLR_ACC  = 3'b001;
  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_XNOR_ACC = 3'b010;
  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_READ_ACC = 3'b011;
  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_SIGN     = 3'b100;
  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_SET_TH   = 3'b101;
  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_LOAD_ACC = 3'b110;
  localparam logic [BNN_OP_WIDTH-1:0] BNN_OP_RSVD     = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StBusy = 2'b01,
    StDone = 2'b10
  } bnn_state_e;

endpackage

// File: rtl/zeroriscy_popcnt8.sv
// Combinational population count of one byte.
module zeroriscy_popcnt8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'd0, data_i[i]};
    end
  end

endmodule

// File: rtl/zeroriscy_bnn_xnor_acc.sv
// BNN execution unit: weight buffer, signed accumulator and threshold, with a
// byte-serial XNOR-popcount accumulate answering the EX unit en/ready handshake.
module zeroriscy_bnn_xnor_acc
  import zeroriscy_defines::*;
#(
  parameter int unsigned NUM_WORDS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bnn_en_i,
  input  logic [BNN_OP_WIDTH-1:0] bnn_operator_i,
  input  logic [31:0]             bnn_addr_i,
  input  logic [31:0]             bnn_data_i,
  output logic [31:0]             bnn_result_o,
  output logic                    bnn_ready_o
);

  localparam int unsigned IdxW = $clog2(NUM_WORDS);

  bnn_state_e  state_q, state_d;
  logic [31:0] w_q [NUM_WORDS];
  logic [31:0] acc_q, acc_d;
  logic [31:0] thr_q, thr_d;
  logic [31:0] x_q, x_d;
  logic [5:0]  part_q, part_d;
  logic [1:0]  cnt_q, cnt_d;

  logic            w_we;
  logic [IdxW-1:0] idx;
  logic [3:0]      byte_cnt;
  logic [31:0]     xnor_sum;

  assign idx = bnn_addr_i[IdxW-1:0];

  zeroriscy_popcnt8 u_popcnt8 (
    .data_i  (x_q[8*cnt_q +: 8]),
    .count_o (byte_cnt)
  );

  // part is at most 32, so {part,0} - 32 lands in [-32, 32].
  assign xnor_sum = acc_q + {25'd0, part_q, 1'b0} - 32'd32;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    thr_d        = thr_q;
    x_d          = x_q;
    part_d       = part_q;
    cnt_d        = cnt_q;
    w_we         = 1'b0;
    bnn_ready_o  = 1'b0;
    bnn_result_o = 32'd0;

    unique case (state_q)
      StIdle: begin
        if (bnn_en_i) begin
          case (bnn_operator_i)
            BNN_OP_LOAD_W: begin
              bnn_ready_o = 1'b1;
              w_we        = 1'b1;
            end
            BNN_OP_CLR_ACC: begin
              bnn_ready_o = 1'b1;
              acc_d       = 32'd0;
            end
            BNN_OP_XNOR_ACC: begin
              x_d     = ~(bnn_data_i ^ w_q[idx]);
              part_d  = 6'd0;
              cnt_d   = 2'd0;
              state_d = StBusy;
            end
            BNN_OP_READ_ACC: begin
              bnn_ready_o  = 1'b1;
              bnn_result_o = acc_q;
            end
            BNN_OP_SIGN: begin
              bnn_ready_o  = 1'b1;
              bnn_result_o = {31'd0, $signed(acc_q) >= $signed(thr_q)};
            end
            BNN_OP_SET_TH: begin
              bnn_ready_o = 1'b1;
              thr_d       = bnn_data_i;
            end
            BNN_OP_LOAD_ACC: begin
              bnn_ready_o = 1'b1;
              acc_d       = bnn_data_i;
            end
            default: begin
              bnn_ready_o = 1'b1;
            end
          endcase
        end
      end

      StBusy: begin
        if (!bnn_en_i) begin
          state_d = StIdle;
        end else begin
          part_d = part_q + {2'd0, byte_cnt};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
        if (bnn_en_i) begin
          bnn_ready_o  = 1'b1;
          bnn_result_o = xnor_sum;
          acc_d        = xnor_sum;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= 32'd0;
      thr_q   <= 32'd0;
      x_q     <= 32'd0;
      part_q  <= 6'd0;
      cnt_q   <= 2'd0;
      for (int i = 0; i < int'(NUM_WORDS); i++) begin
        w_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      thr_q   <= thr_d;
      x_q     <= x_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      if (w_we) begin
        w_q[idx] <= bnn_data_i;
      end
    end
  end

endmodule

// File: tb/tb_zeroriscy_bnn_xnor_acc.sv
// Self-checking bench for zeroriscy_bnn_xnor_acc: directed corner cases plus a
// randomized op stream against an arithmetic reference model.
module tb_zeroriscy_bnn_xnor_acc;

  logic        clk;
  logic        rst;
  logic        en;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] result;
  logic        ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]        m_w [16];
  logic signed [31:0] m_acc;
  logic signed [31:0] m_thr;

  zeroriscy_bnn_xnor_acc #(
    .NUM_WORDS (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bnn_en_i       (en),
    .bnn_operator_i (op),
    .bnn_addr_i     (addr),
    .bnn_data_i     (data),
    .bnn_result_o   (result),
    .bnn_ready_o    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_w[i] = 32'd0;
    m_acc = 0;
    m_thr = 0;
  endtask

  task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] exp);
    logic [3:0] i;
    i   = a[3:0];
    exp = 32'd0;
    case (o)
      3'd0: m_w[i] = d;
      3'd1: m_acc = 0;
      3'd2: begin
        m_acc = m_acc + 2 * $countones(~(d ^ m_w[i])) - 32;
        exp   = m_acc;
      end
      3'd3: exp = m_acc;
      3'd4: exp = (m_acc >= m_thr) ? 32'd1 : 32'd0;
      3'd5: m_thr = d;
      3'd6: m_acc = d;
      default: ;
    endcase
  endtask

  // Holds en until ready; returns at #1 after the handshake edge with en still high.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] res, output int lat);
    bit done;
    en   = 1'b1;
    op   = o;
    addr = a;
    data = d;
    res  = 32'd0;
    lat  = -1;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (ready) begin
        res  = result;
        lat  = c;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      check_eq("handshake_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic go_idle();
    en = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", {31'd0, ready}, 32'd0);
    check_eq("idle_result", result, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] d, input bit gap, output logic [31:0] res);
    logic [31:0] exp;
    int          lat;
    issue(o, a, d, res, lat);
    model_op(o, a, d, exp);
    check_eq({tag, "_result"}, res, exp);
    check_eq({tag, "_latency"}, lat, (o == 3'd2) ? 32'd5 : 32'd0);
    if (gap) go_idle();
  endtask

  logic [31:0] r;
  logic [31:0] rd;
  logic [2:0]  rop;

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    op   = 3'd0;
    addr = 32'd0;
    data = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_ready", {31'd0, ready}, 32'd0);
    check_eq("reset_result", result, 32'd0);
    @(posedge clk);
    #1;

    // Popcount maximum.
    run("loadw3", 3'd0, 32'd3, 32'hFFFF0000, 1, r);
    run("xnor_max", 3'd2, 32'd3, 32'hFFFF0000, 1, r);
    check_eq("xnor_max_const", r, 32'h00000020);
    run("read_max", 3'd3, 32'd0, 32'd0, 1, r);
    check_eq("read_max_const", r, 32'h00000020);

    // Signed threshold with acc = 32.
    run("setth16", 3'd5, 32'd0, 32'h10, 1, r);
    run("sign_32", 3'd4, 32'd0, 32'd0, 1, r);
    check_eq("sign_32_const", r, 32'd1);

    // Popcount minimum with address aliasing.
    run("loadw_alias", 3'd0, 32'h13, 32'hFFFF0000, 1, r);
    run("clr", 3'd1, 32'd0, 32'd0, 1, r);
    run("sign_0", 3'd4, 32'd0, 32'd0, 1, r);
    check_eq("sign_0_const", r, 32'd0);
    run("xnor_min", 3'd2, 32'd3, 32'h0000FFFF, 1, r);
    check_eq("xnor_min_const", r, 32'hFFFFFFE0);
    run("setth0", 3'd5, 32'd0, 32'd0, 1, r);
    run("sign_neg", 3'd4, 32'd0, 32'd0, 1, r);
    check_eq("sign_neg_const", r, 32'd0);

    // Wrap and back-to-back.
    run("loadacc", 3'd6, 32'd0, 32'h7FFFFFF0, 1, r);
    run("xnor_wrap", 3'd2, 32'd3, 32'hFFFF0000, 0, r);
    check_eq("xnor_wrap_const", r, 32'h80000010);
    run("read_b2b", 3'd3, 32'd0, 32'd0, 1, r);
    check_eq("read_b2b_const", r, 32'h80000010);

    // LOAD_W immediately followed by XNOR on the same index.
    run("loadw_b2b", 3'd0, 32'd7, 32'hA5A5A5A5, 0, r);
    run("xnor_b2b", 3'd2, 32'd7, 32'hA5A5A5A5, 1, r);

    // Reserved op.
    run("rsvd", 3'd7, 32'd5, 32'hDEADBEEF, 1, r);
    run("read_rsvd", 3'd3, 32'd0, 32'd0, 1, r);

    // Abort: en dropped at cycle 2 of an XNOR.
    en   = 1'b1;
    op   = 3'd2;
    addr = 32'd3;
    data = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    go_idle();
    run("read_abort", 3'd3, 32'd0, 32'd0, 1, r);
    run("xnor_after_abort", 3'd2, 32'd3, 32'h0F0F0F0F, 1, r);

    // Reset at cycle 3 of an XNOR.
    en   = 1'b1;
    op   = 3'd2;
    addr = 32'd3;
    data = 32'hFFFF0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_ready", {31'd0, ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    go_idle();
    go_idle();
    run("read_after_rst", 3'd3, 32'd0, 32'd0, 1, r);
    check_eq("read_after_rst_const", r, 32'd0);
    run("xnor_zero_w", 3'd2, 32'd3, 32'd0, 1, r);
    check_eq("xnor_zero_w_const", r, 32'h20);

    // Randomized op stream.
    for (int n = 0; n < 300; n++) begin
      rop = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rop = 3'd2;
      rd = $urandom;
      if (rop == 3'd2 && $urandom_range(0, 2) == 0) begin
        addr = $urandom;
        rd   = ($urandom_range(0, 1) == 0) ? m_w[addr[3:0]] : ~m_w[addr[3:0]];
        run("rand", rop, addr, rd, 1'($urandom_range(0, 1)), r);
      end else begin
        run("rand", rop, $urandom, rd, 1'($urandom_range(0, 1)), r);
      end
    end
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
